// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory access scheduler.
//   - state_e : scheduler FSM states (IDLE, BUSY_D, BUSY_F)
//   - AW_DEF / DW_DEF : default address / data widths
//   - CNT_W   : width of the stall-cycle performance counter
//   - sat_inc : saturating increment used by the stall counter
package mem_sched_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_F = 2'd2
   } state_e;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_resp_reg.sv
// Per-port response holder: read-data register plus "access done this step"
// flag. One instance per requester (fetch, data).
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   set_done        - access completed this cycle (mem_ack seen for this port)
//   load            - capture cap_data into rdata (reads only)
//   cap_data        - memory read data
//   clr             - pipeline advances: clear done flag (rdata is kept)
//   rdata, done     - registered outputs
module mem_resp_reg
   import mem_sched_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          set_done,
   input  logic          load,
   input  logic [DW-1:0] cap_data,
   input  logic          clr,
   output logic [DW-1:0] rdata,
   output logic          done
);

   logic [DW-1:0] rdata_d, rdata_q;
   logic          done_d, done_q;

   // Next-state for data register and done flag; completion wins over clear.
   always_comb begin
      rdata_d = rdata_q;
      done_d  = done_q;
      if (load) begin
         rdata_d = cap_data;
      end else begin
         rdata_d = rdata_q;
      end
      if (set_done) begin
         done_d = 1'b1;
      end else if (clr) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end
   end

   // Response state flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= {DW{1'b0}};
         done_q  <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

   assign rdata = rdata_q;
   assign done  = done_q;

endmodule

// File: rtl/mem_access_scheduler.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and the MEM-stage data port. Within a pipeline step the data access
// (older instruction) is served first, then the fetch; `stall` holds the
// pipeline until every access of the step is complete, then drops for
// exactly one advance cycle. Also counts stall cycles (saturating).
// Ports:
//   clk, reset                       - clock, asynchronous active-low reset
//   if_req, if_addr, if_rdata        - fetch request / address / read data
//   d_rd, d_wr, d_addr, d_wdata,
//   d_rdata                          - data load/store request and load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack    - memory handshake
//   stall                            - freeze pipeline registers and PC
//   stall_cnt                        - saturating stall-cycle counter
module mem_access_scheduler
   import mem_sched_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [AW-1:0]    if_addr,
   output logic [DW-1:0]    if_rdata,
   input  logic             d_rd,
   input  logic             d_wr,
   input  logic [AW-1:0]    d_addr,
   input  logic [DW-1:0]    d_wdata,
   output logic [DW-1:0]    d_rdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   input  logic             mem_ack,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e           state_d, state_q;
   logic             mem_req_d, mem_req_q;
   logic             mem_we_d, mem_we_q;
   logic [AW-1:0]    mem_addr_d, mem_addr_q;
   logic [DW-1:0]    mem_wdata_d, mem_wdata_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

   logic f_done_s, d_done_s;
   logic f_set_s, f_load_s, d_set_s, d_load_s;
   logic pend_d_s, pend_f_s, stall_s;

   assign pend_d_s = (d_rd | d_wr) & ~d_done_s;
   assign pend_f_s = if_req & ~f_done_s;
   assign stall_s  = pend_d_s | pend_f_s | (state_q != IDLE);

   // FSM next-state and memory request fields; request fields are only
   // reloaded when entering a BUSY state, otherwise held stable.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      f_set_s     = 1'b0;
      f_load_s    = 1'b0;
      d_set_s     = 1'b0;
      d_load_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_d_s) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_wr;      // rd+wr together resolves to a write
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end else if (pend_f_s) begin
               state_d    = BUSY_F;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
            end else begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         BUSY_D: begin
            if (mem_ack) begin
               d_set_s  = 1'b1;
               d_load_s = ~mem_we_q;
               if (pend_f_s) begin
                  // Chain straight into the fetch without dropping mem_req.
                  state_d    = BUSY_F;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = if_addr;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end else begin
               state_d = BUSY_D;
            end
         end
         BUSY_F: begin
            if (mem_ack) begin
               f_set_s   = 1'b1;
               f_load_s  = 1'b1;
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end else begin
               state_d = BUSY_F;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Stall counter next value.
   always_comb begin
      if (stall_s) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // FSM, registered memory interface and stall counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {AW{1'b0}};
         mem_wdata_q <= {DW{1'b0}};
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   mem_resp_reg #(.DW(DW)) u_resp_f (
      .clk      (clk),
      .reset    (reset),
      .set_done (f_set_s),
      .load     (f_load_s),
      .cap_data (mem_rdata),
      .clr      (~stall_s),
      .rdata    (if_rdata),
      .done     (f_done_s)
   );

   mem_resp_reg #(.DW(DW)) u_resp_d (
      .clk      (clk),
      .reset    (reset),
      .set_done (d_set_s),
      .load     (d_load_s),
      .cap_data (mem_rdata),
      .clr      (~stall_s),
      .rdata    (d_rdata),
      .done     (d_done_s)
   );

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign stall     = stall_s;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Directed bench for mem_access_scheduler with a simple variable-latency
// memory model (ack after wait_n wait cycles, data from a small lookup).
module tb_mem_access_scheduler;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        d_rd;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic [15:0] stall_cnt;

   logic        model_ack;
   logic        force_ack;
   int          wait_n;
   int          wcnt;
   int          n_cmp;
   int          n_err;
   int          n;

   logic        req_log   [16];
   logic        we_log    [16];
   logic [15:0] addr_log  [16];
   logic [15:0] wd_log    [16];

   assign mem_ack = model_ack | force_ack;

   mem_access_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall     (stall),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_data(input logic [15:0] a);
      case (a)
         16'h0010: mem_data = 16'hA5A5;
         16'h0020: mem_data = 16'h1111;
         16'h0100: mem_data = 16'h2222;
         default:  mem_data = a ^ 16'hFFFF;
      endcase
   endfunction

   // Memory model: drives ack/rdata on the falling edge, ack after wait_n waits.
   always @(negedge clk) begin
      if (!reset || !mem_req) begin
         model_ack = 1'b0;
         mem_rdata = 16'hDEAD;
         wcnt      = 0;
      end else if (wcnt >= wait_n) begin
         model_ack = 1'b1;
         mem_rdata = mem_data(mem_addr);
         wcnt      = 0;
      end else begin
         model_ack = 1'b0;
         mem_rdata = 16'hDEAD;
         wcnt      = wcnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Counts stall cycles of one pipeline step, logging the memory interface.
   task automatic run_step(input int limit, output int cnt);
      cnt = 0;
      #1;
      while (stall && cnt < limit) begin
         if (cnt < 16) begin
            req_log[cnt]  = mem_req;
            we_log[cnt]   = mem_we;
            addr_log[cnt] = mem_addr;
            wd_log[cnt]   = mem_wdata;
         end
         cnt++;
         @(negedge clk);
         #1;
      end
      if (stall) check("step_timeout", {31'd0, stall}, 32'd0);
   endtask

   task automatic idle_inputs();
      if_req  = 1'b0;
      if_addr = 16'h0000;
      d_rd    = 1'b0;
      d_wr    = 1'b0;
      d_addr  = 16'h0000;
      d_wdata = 16'h0000;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      force_ack = 1'b0;
      model_ack = 1'b0;
      mem_rdata = 16'hDEAD;
      wait_n = 0;
      wcnt = 0;
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
      check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("rst_if_rdata",  {16'd0, if_rdata}, 32'd0);
      check("rst_d_rdata",   {16'd0, d_rdata}, 32'd0);
      check("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
      reset = 1'b1;

      // No request: idle, and a stray ack in IDLE is ignored.
      @(negedge clk);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      #1;
      check("idle_stall",    {31'd0, stall}, 32'd0);
      check("idle_mem_req",  {31'd0, mem_req}, 32'd0);
      check("idle_if_rdata", {16'd0, if_rdata}, 32'd0);

      // Fetch only, zero-wait.
      if_req = 1'b1; if_addr = 16'h0010;
      run_step(40, n);
      check("t1_stall_cycles", n, 32'd2);
      check("t1_req0",   {31'd0, req_log[0]}, 32'd0);
      check("t1_req1",   {31'd0, req_log[1]}, 32'd1);
      check("t1_addr1",  {16'd0, addr_log[1]}, 32'h0010);
      check("t1_we1",    {31'd0, we_log[1]}, 32'd0);
      check("t1_if_rdata", {16'd0, if_rdata}, 32'hA5A5);
      check("t1_stall_cnt", {16'd0, stall_cnt}, 32'd2);
      @(negedge clk);
      idle_inputs();
      #1;
      check("t1_after_stall", {31'd0, stall}, 32'd0);
      check("t1_rdata_kept", {16'd0, if_rdata}, 32'hA5A5);

      // Data read plus fetch, zero-wait: data first, back-to-back.
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0020;
      d_rd = 1'b1; d_addr = 16'h0100;
      run_step(40, n);
      check("t2_stall_cycles", n, 32'd3);
      check("t2_req1",  {31'd0, req_log[1]}, 32'd1);
      check("t2_addr1", {16'd0, addr_log[1]}, 32'h0100);
      check("t2_req2",  {31'd0, req_log[2]}, 32'd1);
      check("t2_addr2", {16'd0, addr_log[2]}, 32'h0020);
      check("t2_d_rdata",  {16'd0, d_rdata}, 32'h2222);
      check("t2_if_rdata", {16'd0, if_rdata}, 32'h1111);
      check("t2_stall_cnt", {16'd0, stall_cnt}, 32'd5);
      @(negedge clk);
      idle_inputs();

      // Store with 3 wait cycles.
      @(negedge clk);
      wait_n = 3;
      d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
      run_step(40, n);
      check("t3_stall_cycles", n, 32'd5);
      for (int i = 1; i < 5; i++) begin
         check($sformatf("t3_req%0d", i),   {31'd0, req_log[i]}, 32'd1);
         check($sformatf("t3_we%0d", i),    {31'd0, we_log[i]}, 32'd1);
         check($sformatf("t3_addr%0d", i),  {16'd0, addr_log[i]}, 32'h0200);
         check($sformatf("t3_wdata%0d", i), {16'd0, wd_log[i]}, 32'h1234);
      end
      check("t3_d_rdata_kept", {16'd0, d_rdata}, 32'h2222);
      check("t3_stall_cnt", {16'd0, stall_cnt}, 32'd10);
      @(negedge clk);
      idle_inputs();

      // Read and write together: write wins.
      @(negedge clk);
      wait_n = 0;
      d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
      run_step(40, n);
      check("t4_stall_cycles", n, 32'd2);
      check("t4_we1",    {31'd0, we_log[1]}, 32'd1);
      check("t4_addr1",  {16'd0, addr_log[1]}, 32'h0300);
      check("t4_wdata1", {16'd0, wd_log[1]}, 32'hBEEF);
      check("t4_d_rdata_kept", {16'd0, d_rdata}, 32'h2222);
      check("t4_stall_cnt", {16'd0, stall_cnt}, 32'd12);
      @(negedge clk);
      idle_inputs();

      // Asynchronous reset while in BUSY_D.
      @(negedge clk);
      wait_n = 1000000;
      d_rd = 1'b1; d_addr = 16'h0100;
      @(negedge clk);
      #1;
      check("t5_busy_req",  {31'd0, mem_req}, 32'd1);
      check("t5_busy_addr", {16'd0, mem_addr}, 32'h0100);
      reset = 1'b0;
      #1;
      check("t5_rst_req",  {31'd0, mem_req}, 32'd0);
      check("t5_rst_cnt",  {16'd0, stall_cnt}, 32'd0);
      check("t5_rst_addr", {16'd0, mem_addr}, 32'd0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5_post_stall", {31'd0, stall}, 32'd0);
      check("t5_post_req",   {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      wait_n = 0;
      if_req = 1'b1; if_addr = 16'h0010;
      run_step(40, n);
      check("t5_fetch_cycles", n, 32'd2);
      check("t5_if_rdata", {16'd0, if_rdata}, 32'hA5A5);
      check("t5_stall_cnt", {16'd0, stall_cnt}, 32'd2);
      @(negedge clk);
      idle_inputs();

      // Memory never acks: counter saturates without wrapping.
      @(negedge clk);
      wait_n = 1000000;
      if_req = 1'b1; if_addr = 16'h0020;
      repeat (70000) @(negedge clk);
      #1;
      check("t6_stall_cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
      check("t6_stall", {31'd0, stall}, 32'd1);
      check("t6_req",   {31'd0, mem_req}, 32'd1);
      check("t6_addr",  {16'd0, mem_addr}, 32'h0020);
      reset = 1'b0;
      #1;
      check("t6_rst_cnt", {16'd0, stall_cnt}, 32'd0);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
